dmem_resp: RTL and testbench

//   Data-memory responder: the memory-side end of the CPU load/store interface.

---
 rtl/dmem_resp.sv | 121 ++++++++++++
 tb/tb_dmem_resp.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// dmem_resp: memory-side load/store responder with valid/ready request and response channels and WAIT_CYCLES wait states
//   clk        clock, rising edge
//   rst        asynchronous reset, active-low
//   req_*      request channel: valid/ready, we, word-aligned byte addr, wdata, byte enables
//   rsp_*      response channel: valid/ready, rdata (0 for writes and errors), err
module dmem_resp #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int unsigned IW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem [DEPTH_WORDS];
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_be;
    logic [IW-1:0] acc_idx;
    logic        acc_err;
    logic        enter_resp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // With no wait states the access happens on the accept edge itself, so it
    // must use the live request rather than the latched copy.
    always_comb begin
        acc_we     = (state_q == S_IDLE) ? req_we : we_q;
        acc_addr   = (state_q == S_IDLE) ? req_addr : addr_q;
        acc_wdata  = (state_q == S_IDLE) ? req_wdata : wdata_q;
        acc_be     = (state_q == S_IDLE) ? req_be : be_q;
        acc_idx    = acc_addr[IW+1:2];
        acc_err    = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH_WORDS));
        enter_resp = (state_q == S_IDLE) ? (req_valid && WAIT_CYCLES == 0)
                                         : (state_q == S_WAIT && cnt_q == 4'd0);
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (state_q == S_IDLE && req_valid) begin
            we_d    = req_we;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            be_d    = req_be;
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
        end
        if (state_q == S_WAIT) cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        if (enter_resp) begin
            state_d = S_RESP;
            rdata_d = (acc_we || acc_err) ? 32'd0 : mem[acc_idx];
            err_d   = acc_err;
        end
        if (state_q == S_RESP && rsp_ready) begin
            state_d = S_IDLE;
            rdata_d = 32'd0;
            err_d   = 1'b0;
        end
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

    // Storage is not reset; rst gates the write so a zero-wait request that is
    // present while reset is held cannot commit.
    always_ff @(posedge clk) begin
        if (rst && enter_resp && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed scoreboard bench for dmem_resp with 2 and 0 wait states
module tb_dmem_resp;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_we = 2'b00;
    logic [1:0]  rsp_ready = 2'b11;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic [7:0]  req_be = 8'd0;
    wire  [1:0]  req_ready;
    wire  [1:0]  rsp_valid;
    wire  [1:0]  rsp_err;
    wire  [63:0] rsp_rdata;
    typedef struct { logic [31:0] rdata; logic err; } exp_t;
    exp_t sb [$];
    int total = 0;
    int passed = 0;
    int cyc = 0;
    int t0 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]), .req_be(req_be[3:0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[31:0]), .rsp_err(rsp_err[0])
    );

    dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[63:32]), .req_wdata(req_wdata[63:32]), .req_be(req_be[7:4]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[63:32]), .rsp_err(rsp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_idle(input int d, input string tag);
        check({tag, "_ready"}, 32'(req_ready[d]), 32'd1);
        check({tag, "_valid"}, 32'(rsp_valid[d]), 32'd0);
        check({tag, "_rdata"}, rsp_rdata[32*d +: 32], 32'd0);
        check({tag, "_err"}, 32'(rsp_err[d]), 32'd0);
    endtask

    // Drives one request, scrambles the request inputs while busy, and checks
    // latency, hold stability, the scoreboard entry and the return to idle.
    task automatic txn(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] erd, input logic eerr, input int hold);
        int n;
        exp_t e;
        sb.push_back('{erd, eerr});
        req_valid[d] = 1'b1;
        req_we[d] = we;
        req_addr[32*d +: 32] = addr;
        req_wdata[32*d +: 32] = wdata;
        req_be[4*d +: 4] = be;
        rsp_ready[d] = (hold == 0);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                check("busy_ready", 32'(req_ready[d]), 32'd0);
                req_we[d] = ~we;
                req_addr[32*d +: 32] = 32'h0000_0010 ^ addr ^ 32'h0000_0030;
                req_wdata[32*d +: 32] = ~wdata;
                req_be[4*d +: 4] = ~be;
            end
        end while (!rsp_valid[d] && n < 20);
        req_valid[d] = 1'b0;
        check("latency", 32'(n), (d == 0) ? 32'd3 : 32'd1);
        repeat (hold) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(rsp_valid[d]), 32'd1);
            check("hold_ready", 32'(req_ready[d]), 32'd0);
            check("hold_rdata", rsp_rdata[32*d +: 32], erd);
        end
        rsp_ready[d] = 1'b1;
        e = sb.pop_front();
        check("rdata", rsp_rdata[32*d +: 32], e.rdata);
        check("err", 32'(rsp_err[d]), 32'(e.err));
        @(posedge clk);
        #1;
        check_idle(d, "done");
    endtask

    initial begin
        #12;
        check_idle(0, "rst_w2");
        check_idle(1, "rst_w0");
        @(posedge clk);
        #1;
        rst = 1'b1;
        txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0);
        txn(0, 1'b1, 32'h10, 32'h0000_00AA, 4'h1, 32'h0, 1'b0, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, 0);
        txn(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, 0);
        txn(0, 1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1, 0);
        txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1, 0);
        txn(0, 1'b1, 32'h0, 32'h1111_1111, 4'hF, 32'h0, 1'b0, 0);
        txn(0, 1'b1, 32'h1000, 32'h2222_2222, 4'hF, 32'h0, 1'b1, 0);
        txn(0, 1'b1, 32'h12, 32'h3333_3333, 4'hF, 32'h0, 1'b1, 0);
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h1111_1111, 1'b0, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, 5);
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h1111_1111, 1'b0, 0);
        t0 = cyc;
        txn(1, 1'b1, 32'h10, 32'hABCD_0123, 4'hF, 32'h0, 1'b0, 0);
        txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hABCD_0123, 1'b0, 0);
        txn(1, 1'b1, 32'h14, 32'h0000_55AA, 4'h3, 32'h0, 1'b0, 0);
        txn(1, 1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1, 0);
        check("b2b_cycles", 32'(cyc - t0), 32'd8);
        txn(0, 1'b1, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0, 0);
        req_valid[0] = 1'b1;
        req_we[0] = 1'b1;
        req_addr[31:0] = 32'h20;
        req_wdata[31:0] = 32'h1234_5678;
        req_be[3:0] = 4'hF;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        check("abort_busy", 32'(req_ready[0]), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check_idle(0, "abort");
        repeat (3) begin
            @(posedge clk);
            #1;
            check("abort_no_rsp", 32'(rsp_valid[0]), 32'd0);
        end
        rst = 1'b1;
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
